// File: rtl/tohost_monitor.sv
// tohost_monitor
//   End-of-test responder for riscv-tests running on the pipeline core. It
//   watches the core's data-store bus, decodes full-word stores to the
//   tohost word and latches a PASS / FAIL / TIMEOUT verdict. It also latches
//   the failing test number and the number of RUN cycles elapsed, so benches
//   and FPGA builds can read the result from ports.
//
// Parameters
//   TOHOST_ADDR     byte address of the tohost word
//   TIMEOUT_CYCLES  RUN cycles allowed before the TIMEOUT verdict (>= 1)
//   CNT_W           cycle counter width; 2**CNT_W must exceed TIMEOUT_CYCLES
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset (0 = reset)
//   wr_valid   core presents a store
//   wr_ready   monitor accepts the store (registered, 1 from the first edge
//              after reset release)
//   wr_addr    store byte address
//   wr_data    store data
//   wr_strb    store byte enables
//   done       a verdict has been reached (pass | fail | timeout)
//   pass       tohost was written with 1
//   fail       tohost was written with an odd value other than 1
//   timeout    no verdict within TIMEOUT_CYCLES
//   test_num   wr_data[31:1] of the failing write, 0 otherwise
//   cycles     RUN cycles elapsed since reset release; frozen once done
//   fsm_state  one-hot verdict state {TIMEOUT, FAIL, PASS, RUN}, for checkers
//
// Handshake: a store transfers on a rising edge where wr_valid and wr_ready
// are both 1. wr_ready never drops after the first post-reset edge, so the
// core is never stalled; stores that do not hit tohost with all four strobes
// set are still acknowledged and then ignored.

module tohost_monitor #(
    parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
    parameter int          TIMEOUT_CYCLES = 5000,
    parameter int          CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [31:0]      wr_addr,
    input  logic [31:0]      wr_data,
    input  logic [3:0]       wr_strb,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [30:0]      test_num,
    output logic [CNT_W-1:0] cycles,
    output logic [3:0]       fsm_state
);

    // One-hot encoding: each verdict output is a bit of the state register,
    // so the verdict outputs are glitch-free registered values.
    localparam logic [3:0] ST_RUN     = 4'b0001;
    localparam logic [3:0] ST_PASS    = 4'b0010;
    localparam logic [3:0] ST_FAIL    = 4'b0100;
    localparam logic [3:0] ST_TIMEOUT = 4'b1000;

    // Last RUN count value before the timeout verdict fires; the transition
    // edge itself still increments, leaving cycles == TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [3:0]       state_q;
    logic [3:0]       state_d;
    logic             ready_q;
    logic [30:0]      test_num_q;
    logic [CNT_W-1:0] cycles_q;

    logic xfer;
    logic hit;
    logic is_pass_wr;
    logic is_fail_wr;
    logic in_run;

    // ------------------------------------------------------------------
    // Store decode
    // ------------------------------------------------------------------
    always_comb begin
        xfer       = wr_valid & ready_q;
        hit        = xfer && (wr_addr == TOHOST_ADDR) && (wr_strb == 4'hF);
        is_pass_wr = hit && (wr_data == 32'h0000_0001);
        // Odd values other than 1 carry the failing test number in [31:1].
        // Even values (syscall encodings, including 0) are ignored.
        is_fail_wr = hit && wr_data[0] && (wr_data != 32'h0000_0001);
        in_run     = (state_q == ST_RUN);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // A terminal write beats the timeout limit on the same edge because it
    // is tested first. Terminal states hold until reset.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (is_pass_wr) begin
                    state_d = ST_PASS;
                end else if (is_fail_wr) begin
                    state_d = ST_FAIL;
                end else if (cycles_q == LIMIT) begin
                    state_d = ST_TIMEOUT;
                end
            end
            ST_PASS:    state_d = ST_PASS;
            ST_FAIL:    state_d = ST_FAIL;
            ST_TIMEOUT: state_d = ST_TIMEOUT;
            default:    state_d = ST_RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        pass      = state_q[1];
        fail      = state_q[2];
        timeout   = state_q[3];
        done      = |state_q[3:1];
        fsm_state = state_q;
    end

    // ------------------------------------------------------------------
    // Ready: low in reset, high from the first edge after release onward.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Cycle counter: counts every RUN edge, including the edge that moves
    // to a terminal state, then freezes. CNT_W is sized so the timeout
    // verdict arrives before the counter could wrap.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycles_q <= '0;
        end else if (in_run) begin
            cycles_q <= cycles_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Failing test number: captured only on the RUN -> FAIL edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            test_num_q <= '0;
        end else if (in_run && !is_pass_wr && is_fail_wr) begin
            test_num_q <= wr_data[31:1];
        end
    end

    assign wr_ready = ready_q;
    assign test_num = test_num_q;
    assign cycles   = cycles_q;

endmodule

// File: tb/tb_tohost_monitor.sv
// Bench for tohost_monitor. Two instances share the clock and the store bus:
// dut_a uses the production timeout of 5000 cycles, dut_b a short timeout of
// 16 cycles so the limit and its boundary can be reached quickly. Each has
// its own reset. Expected verdict vectors {done, pass, fail, timeout,
// test_num, cycles} are pushed to exp_q when a stimulus step is driven and
// popped and compared once the DUT has taken the edge.

module tb_tohost_monitor;

    localparam logic [31:0] TOHOST = 32'h0000_1000;
    localparam int          CNT_W  = 16;

    logic             clk = 1'b0;
    logic             rst_a;
    logic             rst_b;
    logic             wr_valid;
    logic [31:0]      wr_addr;
    logic [31:0]      wr_data;
    logic [3:0]       wr_strb;

    logic             ready_a, done_a, pass_a, fail_a, timeout_a;
    logic [30:0]      test_num_a;
    logic [CNT_W-1:0] cycles_a;
    logic [3:0]       state_a;

    logic             ready_b, done_b, pass_b, fail_b, timeout_b;
    logic [30:0]      test_num_b;
    logic [CNT_W-1:0] cycles_b;
    logic [3:0]       state_b;

    logic [50:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          edges = 0;
    bit          sel_b = 1'b0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    tohost_monitor #(
        .TOHOST_ADDR(TOHOST), .TIMEOUT_CYCLES(5000), .CNT_W(CNT_W)
    ) dut_a (
        .clk(clk), .rst(rst_a),
        .wr_valid(wr_valid), .wr_ready(ready_a),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .done(done_a), .pass(pass_a), .fail(fail_a), .timeout(timeout_a),
        .test_num(test_num_a), .cycles(cycles_a), .fsm_state(state_a)
    );

    tohost_monitor #(
        .TOHOST_ADDR(TOHOST), .TIMEOUT_CYCLES(16), .CNT_W(CNT_W)
    ) dut_b (
        .clk(clk), .rst(rst_b),
        .wr_valid(wr_valid), .wr_ready(ready_b),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .done(done_b), .pass(pass_b), .fail(fail_b), .timeout(timeout_b),
        .test_num(test_num_b), .cycles(cycles_b), .fsm_state(state_b)
    );

    // ---------------- helpers ----------------
    function automatic logic [50:0] verdict(input bit d, input bit p,
                                            input bit f, input bit t,
                                            input logic [30:0] tn,
                                            input logic [15:0] cyc);
        return {d, p, f, t, tn, cyc};
    endfunction

    function automatic logic [50:0] observed();
        if (sel_b)
            return {done_b, pass_b, fail_b, timeout_b, test_num_b, cycles_b};
        return {done_a, pass_a, fail_a, timeout_a, test_num_a, cycles_a};
    endfunction

    function automatic logic cur_ready();
        return sel_b ? ready_b : ready_a;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic push_exp(input logic [50:0] v);
        exp_q.push_back(v);
    endtask

    task automatic score(input string tag);
        logic [50:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_empty_q"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, {13'd0, observed()}, {13'd0, e});
        end
    endtask

    // ---------------- drivers ----------------
    // All driving and sampling happens 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb);
        wr_valid = 1'b1;
        wr_addr  = addr;
        wr_data  = data;
        wr_strb  = strb;
        step(1);
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_strb  = '0;
    endtask

    task automatic reset_dut(input bit which_b, input string tag);
        sel_b    = which_b;
        wr_valid = 1'b0;
        if (which_b) rst_b = 1'b0; else rst_a = 1'b0;
        #2;
        push_exp(verdict(0, 0, 0, 0, 31'd0, 16'd0));
        score({tag, "_rst_vec"});
        check({tag, "_rst_ready"}, {63'd0, cur_ready()}, 64'd0);
        @(posedge clk);
        #1;
        if (which_b) rst_b = 1'b1; else rst_a = 1'b1;
        edges = 0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_a    = 1'b0;
        rst_b    = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_strb  = '0;
        #3;

        // T1: PASS on the 10th edge after release.
        reset_dut(0, "t1");
        step(9);
        store(TOHOST, 32'h1, 4'hF);
        push_exp(verdict(1, 1, 0, 0, 31'd0, 16'd10));
        score("t1_pass");
        check("t1_ready", {63'd0, cur_ready()}, 64'd1);
        step(3);
        push_exp(verdict(1, 1, 0, 0, 31'd0, 16'd10));
        score("t1_frozen");

        // T2: FAIL with test number 3, later PASS write has no effect.
        reset_dut(0, "t2");
        step(2);
        store(TOHOST, 32'h7, 4'hF);
        push_exp(verdict(1, 0, 1, 0, 31'd3, 16'd3));
        score("t2_fail");
        store(TOHOST, 32'h1, 4'hF);
        push_exp(verdict(1, 0, 1, 0, 31'd3, 16'd3));
        score("t2_sticky");
        store(TOHOST, 32'h9, 4'hF);
        push_exp(verdict(1, 0, 1, 0, 31'd3, 16'd3));
        score("t2_tn_held");

        // T3: non-matching stores are acked and ignored.
        reset_dut(0, "t3");
        // Edge 1: wr_ready is still 0, so even a matching store is not taken.
        store(TOHOST, 32'h1, 4'hF);
        push_exp(verdict(0, 0, 0, 0, 31'd0, 16'd1));
        score("t3_not_ready");
        store(TOHOST + 32'd4, 32'h1, 4'hF);
        push_exp(verdict(0, 0, 0, 0, 31'd0, 16'd2));
        score("t3_wrong_addr");
        check("t3_ready", {63'd0, cur_ready()}, 64'd1);
        store(TOHOST, 32'h1, 4'h3);
        push_exp(verdict(0, 0, 0, 0, 31'd0, 16'd3));
        score("t3_part_strb");
        store(TOHOST, 32'h2, 4'hF);
        push_exp(verdict(0, 0, 0, 0, 31'd0, 16'd4));
        score("t3_even_data");
        store(TOHOST, 32'h0, 4'hF);
        push_exp(verdict(0, 0, 0, 0, 31'd0, 16'd5));
        score("t3_zero_data");
        // Random non-tohost stores with odd data never produce a verdict.
        for (int i = 0; i < 6; i++) begin
            store(TOHOST + 32'($urandom_range(1, 255)) * 4, {$urandom_range(0, 32'h7fff), 1'b1} , 4'hF);
            push_exp(verdict(0, 0, 0, 0, 31'd0, 16'(edges)));
            score("t3_rand_addr");
        end

        // T4: TIMEOUT at the 16th edge.
        reset_dut(1, "t4");
        step(15);
        push_exp(verdict(0, 0, 0, 0, 31'd0, 16'd15));
        score("t4_before_limit");
        step(1);
        push_exp(verdict(1, 0, 0, 1, 31'd0, 16'd16));
        score("t4_timeout");
        step(5);
        push_exp(verdict(1, 0, 0, 1, 31'd0, 16'd16));
        score("t4_frozen");
        store(TOHOST, 32'h1, 4'hF);
        push_exp(verdict(1, 0, 0, 1, 31'd0, 16'd16));
        score("t4_sticky");

        // T5: terminal write on the limit edge beats the timeout.
        reset_dut(1, "t5");
        step(15);
        store(TOHOST, 32'h1, 4'hF);
        push_exp(verdict(1, 1, 0, 0, 31'd0, 16'd16));
        score("t5_pass_wins");
        reset_dut(1, "t5f");
        step(15);
        store(TOHOST, 32'h5, 4'hF);
        push_exp(verdict(1, 0, 1, 0, 31'd2, 16'd16));
        score("t5_fail_wins");

        // T6: asynchronous reset between edges after PASS.
        reset_dut(0, "t6");
        step(4);
        store(TOHOST, 32'h1, 4'hF);
        push_exp(verdict(1, 1, 0, 0, 31'd0, 16'd5));
        score("t6_pass");
        #3;
        rst_a = 1'b0;
        #1;
        push_exp(verdict(0, 0, 0, 0, 31'd0, 16'd0));
        score("t6_async_clear");
        check("t6_ready_clear", {63'd0, cur_ready()}, 64'd0);
        #1;
        rst_a = 1'b1;
        edges = 0;
        step(1);
        push_exp(verdict(0, 0, 0, 0, 31'd0, 16'd1));
        score("t6_restart");
        store(TOHOST, 32'h5, 4'hF);
        push_exp(verdict(1, 0, 1, 0, 31'd2, 16'd2));
        score("t6_fail");

        // Random failing test numbers on the long-timeout instance.
        for (int i = 0; i < 4; i++) begin
            logic [30:0] tn;
            int          gap;
            tn  = 31'($urandom_range(1, 32'h7fff_fffe));
            gap = $urandom_range(1, 20);
            reset_dut(0, "rnd");
            step(gap);
            store(TOHOST, {tn, 1'b1}, 4'hF);
            push_exp(verdict(1, 0, 1, 0, tn, 16'(gap + 1)));
            score("rnd_fail");
        end

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
